// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares the single data-memory port between the pipeline MEM stage (CPU)
//   and an external loader/debug master (EXT). The CPU has default priority.
//   EXT gets bounded bursts while the CPU is waiting, and is forced in after
//   STARVE_LIMIT consecutive denied cycles. While EXT owns the port, a pending
//   CPU request is stalled.
//
// Ports
//   i_clk, i_rst_n                      clock, async active-low reset
//   i_cpu_req/we/addr/wdata             CPU access request
//   o_cpu_rdata                         CPU load data (straight from memory)
//   o_cpu_stall                         freeze pipeline
//   i_ext_req/we/addr/wdata             EXT access request (held until granted)
//   o_ext_gnt                           EXT beat accepted this cycle
//   o_ext_rvalid, o_ext_rdata           registered EXT read return
//   o_mem_we/addr/wdata, i_mem_rdata    memory port (combinational read)
//
// States
//   state  | meaning
//   ST_CPU | CPU owns the port; EXT requests are counted toward starvation
//   ST_EXT | EXT owns the port; one beat per cycle while i_ext_req is high
module dmem_port_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int EXT_MAX_BURST = 4,
  parameter int STARVE_LIMIT  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_cpu_stall,
  input  logic              i_ext_req,
  input  logic              i_ext_we,
  input  logic [ADDR_W-1:0] i_ext_addr,
  input  logic [DATA_W-1:0] i_ext_wdata,
  output logic              o_ext_gnt,
  output logic              o_ext_rvalid,
  output logic [DATA_W-1:0] o_ext_rdata,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  typedef enum logic {ST_CPU = 1'b0, ST_EXT = 1'b1} state_t;

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int BW = $clog2(EXT_MAX_BURST + 1);
  localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_LIMIT - 1);
  localparam logic [BW-1:0] BURST_LAST  = BW'(EXT_MAX_BURST - 1);

  state_t          state, state_nxt;
  logic [SW-1:0]   starve_cnt, starve_nxt;
  logic [BW-1:0]   burst_cnt, burst_nxt;
  logic            mem_we_raw;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= ST_CPU;
      starve_cnt   <= '0;
      burst_cnt    <= '0;
      o_ext_rvalid <= 1'b0;
      o_ext_rdata  <= '0;
    end else begin
      state        <= state_nxt;
      starve_cnt   <= starve_nxt;
      burst_cnt    <= burst_nxt;
      o_ext_rvalid <= o_ext_gnt & ~i_ext_we;
      if (o_ext_gnt && !i_ext_we)
        o_ext_rdata <= i_mem_rdata;
    end
  end

  always_comb begin
    state_nxt   = state;
    starve_nxt  = starve_cnt;
    burst_nxt   = burst_cnt;
    o_ext_gnt   = 1'b0;
    o_cpu_stall = 1'b0;
    o_mem_addr  = i_cpu_addr;
    o_mem_wdata = i_cpu_wdata;
    mem_we_raw  = i_cpu_req & i_cpu_we;

    case (state)
      ST_CPU: begin
        if (!i_ext_req) begin
          starve_nxt = '0;
        end else if (!i_cpu_req || starve_cnt == STARVE_LAST) begin
          state_nxt  = ST_EXT;
          starve_nxt = '0;
          burst_nxt  = '0;
        end else begin
          starve_nxt = starve_cnt + SW'(1);
        end
      end
      ST_EXT: begin
        o_mem_addr  = i_ext_addr;
        o_mem_wdata = i_ext_wdata;
        mem_we_raw  = i_ext_req & i_ext_we;
        o_ext_gnt   = i_ext_req;
        o_cpu_stall = i_cpu_req;
        if (!i_ext_req) begin
          state_nxt = ST_CPU;
        end else if (burst_cnt == BURST_LAST) begin
          // Counter parks here; the burst only ends once the CPU actually waits.
          if (i_cpu_req)
            state_nxt = ST_CPU;
        end else begin
          burst_nxt = burst_cnt + BW'(1);
        end
      end
      default: state_nxt = ST_CPU;
    endcase
  end

  // Write enable is gated by reset itself so nothing is written while held in reset.
  assign o_mem_we    = mem_we_raw & i_rst_n;
  assign o_cpu_rdata = i_mem_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        ext_req, ext_we;
  logic [31:0] ext_addr, ext_wdata;
  logic        ext_gnt, ext_rvalid;
  logic [31:0] ext_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:63];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .EXT_MAX_BURST(4), .STARVE_LIMIT(8)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr),
    .i_cpu_wdata(cpu_wdata), .o_cpu_rdata(cpu_rdata), .o_cpu_stall(cpu_stall),
    .i_ext_req(ext_req), .i_ext_we(ext_we), .i_ext_addr(ext_addr),
    .i_ext_wdata(ext_wdata), .o_ext_gnt(ext_gnt), .o_ext_rvalid(ext_rvalid),
    .o_ext_rdata(ext_rdata), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0; cpu_wdata = 32'h1234;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = 32'h0; ext_wdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
    checks++; if (ext_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b expected 0", ext_rvalid); end
    checks++; if (ext_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", ext_rdata); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", cpu_stall); end
    next_cycle();
    rst_n = 1'b1;
    #1;
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL post_reset_cpu_we: got %b expected 1", mem_we); end
    checks++; if (ext_gnt !== 1'b0) begin errors++; $display("FAIL post_reset_gnt: got %b expected 0", ext_gnt); end
    next_cycle();
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic test_ext_idle();
    cpu_req = 1'b0;
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h10; ext_wdata = 32'hA5A5_0000;
    @(negedge clk);
    checks++; if (ext_gnt !== 1'b0) begin errors++; $display("FAIL idle_gnt_wait: got %b expected 0", ext_gnt); end
    next_cycle();
    @(negedge clk);
    checks++; if (ext_gnt !== 1'b1) begin errors++; $display("FAIL idle_gnt_write: got %b expected 1", ext_gnt); end
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL idle_mem_we: got %b expected 1", mem_we); end
    checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL idle_mem_addr: got %h expected 10", mem_addr); end
    next_cycle();
    ext_we = 1'b0;
    @(negedge clk);
    checks++; if (ext_gnt !== 1'b1) begin errors++; $display("FAIL idle_gnt_read: got %b expected 1", ext_gnt); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL idle_read_we: got %b expected 0", mem_we); end
    checks++; if (ext_rvalid !== 1'b0) begin errors++; $display("FAIL idle_rvalid_after_write: got %b expected 0", ext_rvalid); end
    next_cycle();
    ext_req = 1'b0;
    @(negedge clk);
    checks++; if (ext_rvalid !== 1'b1) begin errors++; $display("FAIL idle_rvalid: got %b expected 1", ext_rvalid); end
    checks++; if (ext_rdata !== 32'hA5A5_0000) begin errors++; $display("FAIL idle_rdata: got %h expected a5a50000", ext_rdata); end
    next_cycle();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    @(negedge clk);
    checks++; if (ext_rvalid !== 1'b0) begin errors++; $display("FAIL idle_rvalid_pulse: got %b expected 0", ext_rvalid); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL idle_cpu_stall: got %b expected 0", cpu_stall); end
    checks++; if (cpu_rdata !== 32'hA5A5_0000) begin errors++; $display("FAIL idle_cpu_rdata: got %h expected a5a50000", cpu_rdata); end
    next_cycle();
    cpu_req = 1'b0;
  endtask

  task automatic test_starvation();
    int first_gnt = 0;
    int n_gnt = 0;
    int n_stall = 0;
    int n_mis = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0;
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h30; ext_wdata = 32'hBEEF;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (ext_gnt === 1'b1) begin
        if (first_gnt == 0) first_gnt = c;
        n_gnt++;
      end
      if (cpu_stall === 1'b1) n_stall++;
      if (cpu_stall !== ext_gnt) n_mis++;
      next_cycle();
    end
    checks++; if (first_gnt != 9) begin errors++; $display("FAIL starve_first_gnt: got %0d expected 9", first_gnt); end
    checks++; if (n_gnt != 4) begin errors++; $display("FAIL starve_beats: got %0d expected 4", n_gnt); end
    checks++; if (n_stall != 4) begin errors++; $display("FAIL starve_stall_cycles: got %0d expected 4", n_stall); end
    checks++; if (n_mis != 0) begin errors++; $display("FAIL starve_stall_vs_gnt: got %0d expected 0", n_mis); end
    checks++; if (mem[12] !== 32'hBEEF) begin errors++; $display("FAIL starve_ext_write: got %h expected beef", mem[12]); end
    ext_req = 1'b0; cpu_req = 1'b0;
    next_cycle();
  endtask

  task automatic test_burst_preempt();
    int n_gnt = 0;
    int last_gnt = 0;
    int n_stall = 0;
    cpu_req = 1'b0; cpu_we = 1'b0;
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h40; ext_wdata = 32'h0;
    next_cycle();
    for (int c = 1; c <= 12; c++) begin
      cpu_req = (c >= 7);
      ext_wdata = c;
      @(negedge clk);
      if (ext_gnt === 1'b1) begin n_gnt++; last_gnt = c; end
      if (cpu_stall === 1'b1) n_stall++;
      next_cycle();
    end
    checks++; if (n_gnt != 7) begin errors++; $display("FAIL burst_beats: got %0d expected 7", n_gnt); end
    checks++; if (last_gnt != 7) begin errors++; $display("FAIL burst_last_beat: got %0d expected 7", last_gnt); end
    checks++; if (n_stall != 1) begin errors++; $display("FAIL burst_stall_cycles: got %0d expected 1", n_stall); end
    checks++; if (mem[16] !== 32'd7) begin errors++; $display("FAIL burst_last_data: got %h expected 7", mem[16]); end
    ext_req = 1'b0; cpu_req = 1'b0;
    next_cycle();
  endtask

  task automatic test_reset_mid_burst();
    cpu_req = 1'b0; cpu_we = 1'b0;
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h50; ext_wdata = 32'h77;
    next_cycle();
    @(negedge clk);
    checks++; if (ext_gnt !== 1'b1) begin errors++; $display("FAIL rstmid_beat1: got %b expected 1", ext_gnt); end
    next_cycle();
    @(negedge clk);
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL rstmid_beat2_we: got %b expected 1", mem_we); end
    rst_n = 1'b0;
    #1;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rstmid_we_in_reset: got %b expected 0", mem_we); end
    checks++; if (ext_gnt !== 1'b0) begin errors++; $display("FAIL rstmid_gnt_in_reset: got %b expected 0", ext_gnt); end
    next_cycle();
    rst_n = 1'b1;
    #1;
    checks++; if (ext_gnt !== 1'b0) begin errors++; $display("FAIL rstmid_gnt_after_reset: got %b expected 0", ext_gnt); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rstmid_we_after_reset: got %b expected 0", mem_we); end
    next_cycle();
    @(negedge clk);
    checks++; if (ext_gnt !== 1'b1) begin errors++; $display("FAIL rstmid_regrant: got %b expected 1", ext_gnt); end
    ext_req = 1'b0;
    next_cycle();
    next_cycle();
  endtask

  task automatic test_contention();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h1;
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h20; ext_wdata = 32'h2;
    @(negedge clk);
    checks++; if (ext_gnt !== 1'b0) begin errors++; $display("FAIL cont_cpu_wins_gnt: got %b expected 0", ext_gnt); end
    checks++; if (mem_wdata !== 32'h1) begin errors++; $display("FAIL cont_cpu_wdata: got %h expected 1", mem_wdata); end
    next_cycle();
    cpu_req = 1'b0;
    @(negedge clk);
    checks++; if (mem[8] !== 32'h1) begin errors++; $display("FAIL cont_mem_after_cpu: got %h expected 1", mem[8]); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL cont_idle_we: got %b expected 0", mem_we); end
    next_cycle();
    @(negedge clk);
    checks++; if (ext_gnt !== 1'b1) begin errors++; $display("FAIL cont_ext_gnt: got %b expected 1", ext_gnt); end
    checks++; if (mem_wdata !== 32'h2) begin errors++; $display("FAIL cont_ext_wdata: got %h expected 2", mem_wdata); end
    next_cycle();
    ext_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0;
    @(negedge clk);
    checks++; if (mem[8] !== 32'h2) begin errors++; $display("FAIL cont_mem_final: got %h expected 2", mem[8]); end
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL cont_drop_stall: got %b expected 1", cpu_stall); end
    checks++; if (ext_gnt !== 1'b0) begin errors++; $display("FAIL cont_drop_gnt: got %b expected 0", ext_gnt); end
    next_cycle();
    @(negedge clk);
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL cont_stall_release: got %b expected 0", cpu_stall); end
    checks++; if (cpu_rdata !== 32'h2) begin errors++; $display("FAIL cont_cpu_rdata: got %h expected 2", cpu_rdata); end
    next_cycle();
    cpu_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    test_reset();
    test_ext_idle();
    test_starvation();
    test_burst_preempt();
    test_reset_mid_burst();
    test_contention();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
